// File: rtl/byte_serial_wide_adder_if.sv
// byte_serial_wide_adder_if: operand/result handshake bundle for the byte-serial adder
interface byte_serial_wide_adder_if #(
  parameter int NUM_BYTES = 4
);
  localparam int W = 8 * NUM_BYTES;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic in_cin;
  logic in_sub;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_sum;
  logic out_cout;
  logic busy;
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input in_ready, out_valid, out_sum, out_cout, busy
  );
  modport slave (
    input in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/byte_serial_wide_adder.sv
// byte_serial_wide_adder: wide add/subtract computed one byte per cycle, LSB first
module byte_serial_wide_adder #(
  parameter int NUM_BYTES = 4,
  parameter int IDX_W = 2
) (
  input logic clk,
  input logic rst,
  byte_serial_wide_adder_if.slave bus
);
  localparam int W = 8 * NUM_BYTES;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state;
  logic [W-1:0] a_q, b_q, res_q;
  logic carry_q, valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0] a_byte, b_byte, s_byte;
  logic [8:0] c_chain;
  logic last;
  assign last = idx_q == IDX_W'(NUM_BYTES - 1);
  // ripple the stored carry through the 8 full adders of the current byte slice
  always_comb begin
    a_byte = a_q[{idx_q, 3'b000} +: 8];
    b_byte = b_q[{idx_q, 3'b000} +: 8];
    c_chain = '0;
    s_byte = '0;
    c_chain[0] = carry_q;
    for (int i = 0; i < 8; i++) begin
      s_byte[i] = a_byte[i] ^ b_byte[i] ^ c_chain[i];
      c_chain[i+1] = (a_byte[i] & b_byte[i]) | (c_chain[i] & (a_byte[i] ^ b_byte[i]));
    end
  end
  // sequencer: latch operands, step through bytes, hold result until taken
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      carry_q <= 1'b0;
      idx_q <= '0;
      valid_q <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.in_valid) begin
            a_q <= bus.in_a;
            b_q <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_q <= bus.in_sub | bus.in_cin;
            idx_q <= '0;
            state <= ADD;
          end
        ADD: begin
          res_q[{idx_q, 3'b000} +: 8] <= s_byte;
          carry_q <= c_chain[8];
          idx_q <= idx_q + 1'b1;
          if (last) begin
            state <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE:
          if (bus.out_ready) begin
            state <= IDLE;
            valid_q <= 1'b0;
          end
        default: state <= IDLE;
      endcase
  assign bus.in_ready = rst & (state == IDLE);
  assign bus.busy = state != IDLE;
  assign bus.out_valid = valid_q;
  assign bus.out_sum = res_q;
  assign bus.out_cout = carry_q;
endmodule

// File: tb/tb_byte_serial_wide_adder.sv
// tb_byte_serial_wide_adder: directed vectors checked against an arithmetic model
module tb_byte_serial_wide_adder;
  localparam int NB = 4;
  localparam int W = 8 * NB;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  byte_serial_wide_adder_if #(.NUM_BYTES(NB)) bus ();
  byte_serial_wide_adder #(.NUM_BYTES(NB), .IDX_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    return sub ? {1'b0, a} + {1'b0, ~b} + (W+1)'(1) : {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction
  // every cycle a result is presented it must match the oldest outstanding model result
  always @(negedge clk)
    if (rst && bus.out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", bus.out_valid, 0);
      else begin
        chk("cmp_sum", bus.out_sum, exp_q[0][W-1:0]);
        chk("cmp_cout", bus.out_cout, exp_q[0][W]);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                     input logic [W-1:0] lit_sum, input logic lit_cout, input int hold);
    logic [W:0] m;
    logic [W-1:0] s0;
    logic c0;
    int cyc;
    m = model(a, b, cin, sub);
    chk("model_sum", m[W-1:0], lit_sum);
    chk("model_cout", m[W], lit_cout);
    @(posedge clk); #1;
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_cin = cin;
    bus.in_sub = sub;
    bus.in_valid = 1'b1;
    exp_q.push_back(m);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a = '1;
    bus.in_b = '0;
    bus.in_sub = ~sub;
    cyc = 0;
    @(negedge clk);
    while (!bus.out_valid && cyc < 20) begin
      chk("in_ready_add", bus.in_ready, 0);
      chk("busy_add", bus.busy, 1);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 4);
    chk("lit_sum", bus.out_sum, lit_sum);
    chk("lit_cout", bus.out_cout, lit_cout);
    chk("busy_done", bus.busy, 1);
    chk("in_ready_done", bus.in_ready, 0);
    s0 = bus.out_sum;
    c0 = bus.out_cout;
    repeat (hold) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_a = bus.in_a + 32'h1111;
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_sum", bus.out_sum, s0);
      chk("hold_cout", bus.out_cout, c0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("in_ready_after", bus.in_ready, 1);
    chk("valid_after", bus.out_valid, 0);
    chk("busy_after", bus.busy, 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_cin = 1'b0;
    bus.in_sub = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sum", bus.out_sum, 0);
    chk("rst_cout", bus.out_cout, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    run(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 5);
    run(32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 0);
    run(32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 1'b1, 1);
    run(32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 0);
    run(32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000001, 1'b1, 2);
    @(posedge clk); #1;
    bus.in_a = 32'h12345678;
    bus.in_b = 32'h01010101;
    bus.in_cin = 1'b0;
    bus.in_sub = 1'b0;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(32'h12345678, 32'h01010101, 1'b0, 1'b0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_sum", bus.out_sum, 0);
    chk("mid_rst_cout", bus.out_cout, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    exp_q.delete();
    repeat (6) @(negedge clk);
    chk("mid_rst_still_idle", bus.out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    run(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("end_idle_valid", bus.out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
